maxpool_seq_ctrl: RTL and testbench
===================================

Name: maxpool_seq_ctrl

Overview:
Sequential controller that performs 2x2 stride-2 max pooling over a D-channel HxW feature map held in an external single-port read memory. It writes the (H/2)x(W/2) result per channel to an external write port, one window at a time, using a single shared comparator instead of a fully parallel array. It sits between the conv-layer output buffer and the next layer's input buffer and is launched by the layer sequencer with a start/done handshake.

Parameters:
DATA_BITS, 32, element width; signed two's complement.
D, 1, number of channels.
W, 46, input width; must be even.
H, 46, input height; must be even.
ADDR_BITS, 16, address width of both memory ports; must cover D*H*W.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; launches a pooling pass when idle.
in_base  input  ADDR_BITS  input map base address; latched on accepted start.
out_base  input  ADDR_BITS  output map base address; latched on accepted start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse after the last write is accepted.
rd_en  output  1  read strobe.
rd_addr  output  ADDR_BITS  read address.
rd_data  input  DATA_BITS  read data; valid exactly 1 cycle after rd_en.
wr_en  output  1  write request; held until accepted.
wr_addr  output  ADDR_BITS  write address.
wr_data  output  DATA_BITS  pooled maximum.
wr_ready  input  1  write accepted when wr_en && wr_ready.

Behaviour:
- Reset is asynchronous, active-low. Reset values: busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0. State=IDLE and all counters=0.
- Layout is row-major and channel-major. Input element (ch,y,x) is at in_base + ch*H*W + y*W + x. Output (ch,r,c) is at out_base + ch*(H/2)*(W/2) + r*(W/2) + c.
- Window (ch,r,c) covers elements A=(2r,2c), B=(2r,2c+1), C=(2r+1,2c), D=(2r+1,2c+1).
- Loop order: c fastest, then r, then ch.
- States:
  - IDLE: on start, latch the bases, clear the counters, go to RD.
  - RD: 4 cycles with rd_cnt 0..3. Issue rd_en with the address of A, B, C, D in order. Data from the read issued on the previous cycle is folded into max_reg. The data for A loads max_reg unconditionally.
  - FOLD: 1 cycle. The data for D is folded. max_reg goes to wr_data, wr_en=1.
  - WR: hold wr_en, wr_addr and wr_data stable until wr_ready. On acceptance, if this was the last window go to DONE, else advance the counters and go to RD.
  - DONE: 1 cycle with done=1 and busy=0, then IDLE.
- Fold rule is signed compare: max_reg <= (rd_data > max_reg) ? rd_data : max_reg. On ties max_reg is kept.
- Throughput: 6 cycles per window with wr_ready tied high, counted from the first RD cycle to the WR accept.
- Total latency from start to done is 6*D*(H/2)*(W/2)+1 cycles when wr_ready is high. Done falls 1 cycle after the last WR accept.
- Counter wrap: c wraps at W/2-1 and increments r. r wraps at H/2-1 and increments ch. The last window is ch=D-1, r=H/2-1, c=W/2-1.
- Address arithmetic is ADDR_BITS-wide and modulo 2^ADDR_BITS with no overflow flag. Addresses are computed incrementally with no multipliers.
- start while busy is ignored, including a start in the DONE cycle. start in the same cycle as a reset deassertion is ignored.
- Reset asserted mid-pass aborts immediately. All outputs return to their reset values and no partial write completes.
- wr_ready stalls: rd_en stays 0 throughout WR, so there are no reads while stalled.
- Elaboration-time error if W or H is odd, or if D*H*W exceeds 2^ADDR_BITS.

Decomposition:
- Package maxpool_pkg holds:
  - the state enum (IDLE, RD, FOLD, WR, DONE) and the state width;
  - the OUT_W=W/2 and OUT_H=H/2 localparam helpers;
  - the function that returns the minimum address width for D*H*W.
- One sub-module, maxpool_cmp_fold. It is the registered signed running-max: inputs load, fold, din; output max_q.
- The address counters stay in the top level.

Test Plan:
- D=1, H=W=4, input 0..15 at in_base=0, out_base=32, wr_ready=1 → writes (32,5),(33,7),(34,13),(35,15). done occurs 25 cycles after start.
- Signed data: window {-3,-7,-1,-9} → wr_data=-1. Window {-5,-5,-5,-5} → -5. Window {0x7FFFFFFF,-1,0,1} → 0x7FFFFFFF.
- D=2, H=W=4: the channel-1 window at r=0,c=0 reads addresses 16,17,20,21 and writes to out_base+4. The last write is at out_base+7.
- Hold wr_ready low for 3 cycles on the first write → wr_en, wr_addr and wr_data stay stable. rd_en stays 0 during the stall. done is delayed by 3 cycles.
- Pulse start mid-pass → no effect on the address sequence. Pulse start in the DONE cycle → ignored, so busy stays 0 the next cycle.
- Assert rst_n low during the RD of window 2 → all outputs go to 0 asynchronously. After release, a new start reruns the pass from window 0.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared types and elaboration helpers for the 2x2 stride-2 max-pool controller.
package maxpool_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    FOLD = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  // Output map dimensions for a given input width / height.
  function automatic int out_w(input int w);
    return w / 2;
  endfunction

  function automatic int out_h(input int h);
    return h / 2;
  endfunction

  // Smallest address width able to reach every element of a d x h x w map.
  function automatic int min_addr_bits(input longint d, input longint h, input longint w);
    return $clog2(d * h * w);
  endfunction

endpackage

// File: rtl/maxpool_seq_ctrl_if.sv
// Launch handshake plus read/write memory ports of the max-pool controller.
interface maxpool_seq_ctrl_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32
);
  // Handshakes: start is a one-cycle request taken only while idle; busy/done report
  // progress. Reads have no back-pressure (rd_data is valid the cycle after rd_en).
  // Writes are valid/ready: wr_en is valid, and wr_addr/wr_data stay fixed from the
  // first wr_en cycle until the cycle where wr_en && wr_ready, which is the transfer.
  logic                 start;
  logic [ADDR_BITS-1:0] in_base;
  logic [ADDR_BITS-1:0] out_base;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;

  modport master (
    input  start, in_base, out_base, rd_data, wr_ready,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, in_base, out_base, rd_data, wr_ready,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/maxpool_cmp_fold.sv
// Registered signed running maximum: load replaces, fold keeps the larger (ties keep).
module maxpool_cmp_fold #(
    parameter int DATA_BITS = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic                        fold,
    input  logic signed [DATA_BITS-1:0] din,
    output logic signed [DATA_BITS-1:0] max_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (load) begin
      max_q <= din;
    end else if (fold && (din > max_q)) begin
      max_q <= din;
    end
  end

endmodule

// File: rtl/maxpool_seq_ctrl.sv
// 2x2 stride-2 max pooling over a D x H x W map, one window at a time through one comparator.
module maxpool_seq_ctrl
  import maxpool_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int D         = 1,
    parameter int W         = 46,
    parameter int H         = 46,
    parameter int ADDR_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    maxpool_seq_ctrl_if.master  bus,
    output state_e              dbg_state
);

  localparam int OUT_W = out_w(W);
  localparam int OUT_H = out_h(H);
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int DW    = (D > 1) ? $clog2(D) : 1;

  typedef logic [ADDR_BITS-1:0] addr_t;

  // Moving to the next window row skips the odd input row: +2 to finish the row, +W more.
  localparam addr_t COL_STEP = addr_t'(2);
  localparam addr_t ROW_STEP = addr_t'(W + 2);
  localparam addr_t OFF_B    = addr_t'(1);
  localparam addr_t OFF_C    = addr_t'(W);
  localparam addr_t OFF_D    = addr_t'(W + 1);

  if (((W % 2) != 0) || ((H % 2) != 0)) begin : g_bad_dims
    $error("maxpool_seq_ctrl: W and H must both be even");
  end
  if (min_addr_bits(longint'(D), longint'(H), longint'(W)) > ADDR_BITS) begin : g_bad_addr
    $error("maxpool_seq_ctrl: ADDR_BITS too small for D*H*W");
  end

  state_e          state, state_n;
  logic            armed;
  logic [1:0]      rd_cnt;
  logic [CW-1:0]   c_cnt;
  logic [RW-1:0]   r_cnt;
  logic [DW-1:0]   ch_cnt;
  addr_t           in_win;
  addr_t           out_win;
  addr_t           rd_addr_c;
  logic            c_last, r_last, ch_last, last_win;
  logic            take_start;
  logic            cmp_load, cmp_fold;
  logic [DATA_BITS-1:0] max_q;

  assign c_last     = (c_cnt == CW'(OUT_W - 1));
  assign r_last     = (r_cnt == RW'(OUT_H - 1));
  assign ch_last    = (ch_cnt == DW'(D - 1));
  assign last_win   = c_last && r_last && ch_last;
  // armed blocks a start sampled on the first edge after reset release.
  assign take_start = armed && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (take_start) state_n = RD;
      RD:      if (rd_cnt == 2'd3) state_n = FOLD;
      FOLD:    state_n = WR;
      WR:      if (bus.wr_ready) state_n = last_win ? DONE : RD;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      rd_cnt  <= 2'd0;
      c_cnt   <= '0;
      r_cnt   <= '0;
      ch_cnt  <= '0;
      in_win  <= '0;
      out_win <= '0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (take_start) begin
            in_win  <= bus.in_base;
            out_win <= bus.out_base;
            rd_cnt  <= 2'd0;
            c_cnt   <= '0;
            r_cnt   <= '0;
            ch_cnt  <= '0;
          end
        end
        RD: rd_cnt <= rd_cnt + 2'd1;
        WR: begin
          if (bus.wr_ready && !last_win) begin
            out_win <= out_win + addr_t'(1);
            if (c_last) begin
              c_cnt  <= '0;
              in_win <= in_win + ROW_STEP;
              if (r_last) begin
                r_cnt  <= '0;
                ch_cnt <= ch_cnt + DW'(1);
              end else begin
                r_cnt <= r_cnt + RW'(1);
              end
            end else begin
              c_cnt  <= c_cnt + CW'(1);
              in_win <= in_win + COL_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_addr_c = in_win;
    unique case (rd_cnt)
      2'd0: rd_addr_c = in_win;
      2'd1: rd_addr_c = in_win + OFF_B;
      2'd2: rd_addr_c = in_win + OFF_C;
      2'd3: rd_addr_c = in_win + OFF_D;
      default: rd_addr_c = in_win;
    endcase
  end

  // Read data lags its address by one cycle: A lands on rd_cnt 1, D lands in FOLD.
  assign cmp_load = (state == RD) && (rd_cnt == 2'd1);
  assign cmp_fold = ((state == RD) && rd_cnt[1]) || (state == FOLD);

  maxpool_cmp_fold #(.DATA_BITS(DATA_BITS)) u_cmp (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cmp_load),
      .fold  (cmp_fold),
      .din   (bus.rd_data),
      .max_q (max_q)
  );

  assign bus.busy    = (state == RD) || (state == FOLD) || (state == WR);
  assign bus.done    = (state == DONE);
  assign bus.rd_en   = (state == RD);
  assign bus.rd_addr = (state == RD) ? rd_addr_c : '0;
  assign bus.wr_en   = (state == WR);
  assign bus.wr_addr = out_win;
  assign bus.wr_data = max_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Self-checking bench for maxpool_seq_ctrl: D=2, 4x4 map, memory model and window-level reference.
module tb_maxpool_seq_ctrl;
  import maxpool_pkg::*;

  localparam int DB   = 32;
  localparam int ND   = 2;
  localparam int NW   = 4;
  localparam int NH   = 4;
  localparam int AB   = 8;
  localparam int OW   = NW / 2;
  localparam int OH   = NH / 2;
  localparam int NWIN = ND * OH * OW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maxpool_seq_ctrl_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();
  state_e dbg_state;

  maxpool_seq_ctrl #(
      .DATA_BITS(DB), .D(ND), .W(NW), .H(NH), .ADDR_BITS(AB)
  ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [DB-1:0] mem [0:(1<<AB)-1];
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;
  logic [AB-1:0] exp_rd_q[$];
  logic [AB-1:0] exp_wa_q[$];
  logic [DB-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every window from the address formulas, max by plain signed comparison.
  task automatic build_expect(input logic [AB-1:0] in_b, input logic [AB-1:0] out_b);
    int off [4];
    logic [AB-1:0] a;
    logic [AB-1:0] ad;
    logic signed [DB-1:0] m;
    off = '{0, 1, NW, NW + 1};
    exp_rd_q.delete();
    exp_wa_q.delete();
    exp_q.delete();
    for (int ch = 0; ch < ND; ch++) begin
      for (int r = 0; r < OH; r++) begin
        for (int c = 0; c < OW; c++) begin
          a = AB'(int'(in_b) + ch * NH * NW + 2 * r * NW + 2 * c);
          m = mem[a];
          for (int k = 0; k < 4; k++) begin
            ad = AB'(int'(a) + off[k]);
            exp_rd_q.push_back(ad);
            if ($signed(mem[ad]) > m) m = mem[ad];
          end
          exp_wa_q.push_back(AB'(int'(out_b) + ch * OH * OW + r * OW + c));
          exp_q.push_back(m);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (bus.rd_en) begin
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 64'(bus.rd_en), 64'd0);
        else chk("rd_addr", 64'(bus.rd_addr), 64'(exp_rd_q.pop_front()));
      end
      if (bus.wr_en) begin
        chk("rd_en_in_wr", 64'(bus.rd_en), 64'd0);
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 64'(bus.wr_en), 64'd0);
        end else begin
          chk("wr_addr", 64'(bus.wr_addr), 64'(exp_wa_q[0]));
          chk("wr_data", 64'(bus.wr_data), 64'(exp_q[0]));
          if (bus.wr_ready) begin
            void'(exp_wa_q.pop_front());
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"},    64'(bus.busy),    64'd0);
    chk({pfx, "_done"},    64'(bus.done),    64'd0);
    chk({pfx, "_rd_en"},   64'(bus.rd_en),   64'd0);
    chk({pfx, "_wr_en"},   64'(bus.wr_en),   64'd0);
    chk({pfx, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
    chk({pfx, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({pfx, "_wr_data"}, 64'(bus.wr_data), 64'd0);
  endtask

  // Cycle 1 is the first cycle after the edge that accepts start.
  task automatic run_pass(input logic [AB-1:0] in_b, input logic [AB-1:0] out_b,
                          input int stall, input int mid_start, input int abort_at,
                          input bit done_start, output int lat);
    int cyc;
    bit aborted;
    build_expect(in_b, out_b);
    mon_on  = 1'b1;
    aborted = 1'b0;
    lat     = -1;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.in_base  = in_b;
    bus.out_base = out_b;
    bus.wr_ready = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_base  = AB'($urandom);
    bus.out_base = AB'($urandom);
    cyc = 1;
    while (cyc < 200 && lat < 0) begin
      bus.wr_ready = !(cyc >= 6 && cyc < 6 + stall);
      bus.start    = (cyc == mid_start);
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        mon_on = 1'b0;
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_q.delete();
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      if (cyc == 1) chk("busy_after_start", 64'(bus.busy), 64'd1);
      if (bus.done) begin
        lat = cyc;
        bus.start = done_start;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start    = 1'b0;
    bus.wr_ready = 1'b1;
    if (!aborted) begin
      chk("done_seen", 64'(lat >= 0), 64'd1);
      @(negedge clk);
      chk("done_one_cycle", 64'(bus.done), 64'd0);
      chk("busy_after_done", 64'(bus.busy), 64'd0);
      chk("rd_left", 64'(exp_rd_q.size()), 64'd0);
      chk("wr_left", 64'(exp_q.size()), 64'd0);
      mon_on = 1'b0;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < (1 << AB); i++) mem[i] = $urandom;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int st;
    bus.start    = 1'b0;
    bus.in_base  = '0;
    bus.out_base = '0;
    bus.wr_ready = 1'b1;
    bus.rd_data  = '0;
    for (int i = 0; i < (1 << AB); i++) mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Ramp data 0..31: channel 0 maxima 5,7,13,15 at 32..35.
    for (int i = 0; i < 32; i++) mem[i] = DB'(i);
    run_pass(8'd0, 8'd32, 0, 0, 0, 1'b0, lat);
    chk("lat_plain", 64'(lat), 64'(6 * NWIN + 1));

    // Signed corner windows, a 3-cycle write stall, start mid-pass and in DONE.
    fill_random();
    mem[40] = -32'sd3;  mem[41] = -32'sd7;  mem[44] = -32'sd1;  mem[45] = -32'sd9;
    mem[42] = -32'sd5;  mem[43] = -32'sd5;  mem[46] = -32'sd5;  mem[47] = -32'sd5;
    mem[48] = 32'h7FFF_FFFF; mem[49] = 32'hFFFF_FFFF; mem[52] = 32'd0; mem[53] = 32'd1;
    run_pass(8'd40, 8'd100, 3, 10, 0, 1'b1, lat);
    chk("lat_stall", 64'(lat), 64'(6 * NWIN + 1 + 3));

    // Address wrap on both ports.
    fill_random();
    st = $urandom_range(0, 4);
    run_pass(8'd240, 8'd252, st, 0, 0, 1'b0, lat);
    chk("lat_wrap", 64'(lat), 64'(6 * NWIN + 1 + st));

    // Reset during window 2, start coincident with release, then a full rerun.
    fill_random();
    run_pass(8'd8, 8'd64, 0, 0, 14, 1'b0, lat);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_at_release_busy", 64'(bus.busy), 64'd0);
    chk("start_at_release_state", 64'(dbg_state), 64'(IDLE));
    run_pass(8'd8, 8'd64, 0, 0, 0, 1'b0, lat);
    chk("lat_rerun", 64'(lat), 64'(6 * NWIN + 1));

    // Random bases, data and stall lengths.
    for (int p = 0; p < 3; p++) begin
      fill_random();
      st = $urandom_range(0, 5);
      run_pass(AB'($urandom), AB'($urandom), st, $urandom_range(2, 40), 0, 1'b0, lat);
      chk("lat_rand", 64'(lat), 64'(6 * NWIN + 1 + st));
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
